// File: rtl/lfsr_timer_pkg.sv
// Shared types and constants for the LFSR timeout generator.
package lfsr_timer_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Default 16-bit polynomial: feedback from bits 15, 4, 2, 1.
    localparam logic [15:0] DEF_TAPS = 16'h8016;
    localparam logic [15:0] DEF_SEED = 16'hFFFF;
    localparam logic [15:0] DEF_TERM = 16'h2167;

    // Small polynomial giving the sequence F,E,C,8 (base period 4).
    localparam logic [3:0] TEST_TAPS = 4'hC;
    localparam logic [3:0] TEST_SEED = 4'hF;
    localparam logic [3:0] TEST_TERM = 4'h8;

endpackage

// File: rtl/lfsr_timer_prescaler.sv
// LFSR prescaler: steps the register while advance is high and emits a
// registered match pulse on reaching TERM. Optional LFSR_TIMER_LOCKUP_EN adds zero-state recovery.
module lfsr_prescaler #(
    parameter int unsigned        WIDTH = 16,
    parameter logic [WIDTH-1:0]   TAPS  = 16'h8016,
    parameter logic [WIDTH-1:0]   SEED  = 16'hFFFF,
    parameter logic [WIDTH-1:0]   TERM  = 16'h2167
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             advance,
    input  logic             reseed,
    output logic             match,
    output logic             at_term,
`ifdef LFSR_TIMER_LOCKUP_EN
    output logic             zero,
`endif
    output logic [WIDTH-1:0] lfsr
);

    logic feedback;

    assign feedback = ^(lfsr & TAPS);
    assign at_term  = (lfsr == TERM);
`ifdef LFSR_TIMER_LOCKUP_EN
    assign zero     = (lfsr == '0);
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr  <= SEED;
            match <= 1'b0;
        end else begin
            match <= 1'b0;
            if (reseed) begin
                lfsr <= SEED;
`ifdef LFSR_TIMER_LOCKUP_EN
            end else if (zero) begin
                lfsr <= SEED;
`endif
            end else if (advance) begin
                if (at_term) begin
                    lfsr  <= SEED;
                    match <= 1'b1;
                end else begin
                    lfsr <= {lfsr[WIDTH-2:0], feedback};
                end
            end
        end
    end

endmodule

// File: rtl/lfsr_timer.sv
// Programmable LFSR-based timeout: prescaler base tick plus a cascaded down-counter.
// Define LFSR_TIMER_LOCKUP_EN to add the lockup output and zero-state recovery.
module lfsr_timer
    import lfsr_timer_pkg::*;
#(
    parameter int unsigned        WIDTH = 16,
    parameter logic [WIDTH-1:0]   TAPS  = DEF_TAPS,
    parameter logic [WIDTH-1:0]   SEED  = DEF_SEED,
    parameter logic [WIDTH-1:0]   TERM  = DEF_TERM,
    parameter int unsigned        CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             enable,
    input  logic             periodic,
    input  logic [CNT_W-1:0] count_in,
    output logic             tick,
    output logic             done,
    output logic             busy,
`ifdef LFSR_TIMER_LOCKUP_EN
    output logic             lockup,
`endif
    output logic [CNT_W-1:0] remaining
);

    state_t             state, state_next;
    logic [CNT_W-1:0]   reload, reload_next, rem_next;
    logic               mode, mode_next, done_next;
    logic               advance, reseed, at_term;
    logic [WIDTH-1:0]   lfsr;
`ifdef LFSR_TIMER_LOCKUP_EN
    logic               zero;
`endif

    lfsr_prescaler #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS),
        .SEED  (SEED),
        .TERM  (TERM)
    ) u_prescaler (
        .clk     (clk),
        .rst     (rst),
        .advance (advance),
        .reseed  (reseed),
        .match   (tick),
        .at_term (at_term),
`ifdef LFSR_TIMER_LOCKUP_EN
        .zero    (zero),
`endif
        .lfsr    (lfsr)
    );

    assign busy = (state == RUN);

    always_comb begin
        state_next  = state;
        rem_next    = remaining;
        reload_next = reload;
        mode_next   = mode;
        done_next   = 1'b0;
        advance     = 1'b0;
        reseed      = 1'b0;
        case (state)
            IDLE: begin
                reseed = 1'b1;
                if (start && !stop) begin
                    reload_next = count_in;
                    mode_next   = periodic;
                    if (count_in != '0) begin
                        state_next = RUN;
                        rem_next   = count_in;
                    end else begin
                        done_next = 1'b1;
                    end
                end
            end
            RUN: begin
                if (stop) begin
                    state_next = IDLE;
                    rem_next   = '0;
                    reseed     = 1'b1;
                end else if (start) begin
                    reseed      = 1'b1;
                    reload_next = count_in;
                    mode_next   = periodic;
                    if (count_in != '0) begin
                        rem_next = count_in;
                    end else begin
                        state_next = IDLE;
                        rem_next   = '0;
                        done_next  = 1'b1;
                    end
                end else begin
                    advance = enable;
                    // The counter acts on the already-registered tick, so a tick
                    // landing in a paused cycle still takes effect.
                    if (tick) begin
                        if (remaining == CNT_W'(1)) begin
                            if (mode) begin
                                rem_next = reload;
                            end else begin
                                state_next = IDLE;
                                rem_next   = '0;
                                reseed     = 1'b1;
                            end
                        end else begin
                            rem_next = remaining - CNT_W'(1);
                        end
                    end
                    if (enable && at_term && remaining == CNT_W'(1)) begin
                        done_next = 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                reseed     = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            remaining <= '0;
            reload    <= '0;
            mode      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_next;
            remaining <= rem_next;
            reload    <= reload_next;
            mode      <= mode_next;
            done      <= done_next;
        end
    end

`ifdef LFSR_TIMER_LOCKUP_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lockup <= 1'b0;
        end else if (start && !stop) begin
            lockup <= 1'b0;
        end else if (state == RUN && zero) begin
            lockup <= 1'b1;
        end
    end
`endif

endmodule

// File: doc/lfsr_timer.md
Name: lfsr_timer

Overview:
- Parametrised LFSR-based timeout generator. Successor to the fixed 16-bit 1 ms LFSR timeout.
- The inner LFSR prescaler produces a periodic base tick (nominally 1 ms).
- A cascaded down-counter counts a programmable number of base ticks.
- Supports one-shot and periodic modes, a start/stop/busy/done handshake, and pause via enable.
- Sits between the game/trainer FSMs and the clock. It replaces ad-hoc chained timeout instances.

Parameters:
- WIDTH, 16, LFSR register width (3..32).
- TAPS, 16'h8016, feedback mask; bit i set means lfsr[i] is XORed into the new lfsr[0]. The default selects bits 15, 4, 2 and 1.
- SEED, 16'hFFFF, LFSR reload value. Must be nonzero.
- TERM, 16'h2167, terminal LFSR value that ends one base period.
- CNT_W, 8, width of the base-tick counter.

Ports:
- clk  in  1  system clock, all logic on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle request: load count_in, reseed the LFSR, begin timing.
- stop  in  1  abort timing, return to IDLE, no done.
- enable  in  1  advance gate; when low in RUN, the LFSR and counter freeze.
- periodic  in  1  mode, sampled at start: 0 = one-shot, 1 = auto-reload.
- count_in  in  CNT_W  number of base ticks per timeout.
- tick  out  1  one-cycle base-period pulse.
- done  out  1  one-cycle pulse when the programmed tick count expires.
- busy  out  1  high in RUN.
- remaining  out  CNT_W  ticks left in the current timeout.

Behaviour:
- Reset (rst=0, asynchronous) values:
  - lfsr=SEED, state=IDLE.
  - tick=0, done=0, busy=0, remaining=0.
  - Stored mode and reload value cleared.
- States: IDLE, RUN.
- IDLE:
  - lfsr held at SEED; tick and done are 0.
  - start=1 captures count_in as reload and periodic as mode, then enters RUN on the next cycle.
  - In RUN, remaining=count_in and lfsr=SEED.
- RUN, each cycle with enable=1:
  - If lfsr==TERM: lfsr<=SEED and tick<=1 on the next cycle. Otherwise shift, with lfsr[WIDTH-1:1]<=lfsr[WIDTH-2:0] and lfsr[0]<=XOR of (lfsr & TAPS).
  - Base period = (steps from SEED to TERM) + 1 clocks.
- RUN, enable=0: lfsr, remaining and state are held; tick=0. enable is not consulted in IDLE.
- Counter:
  - On a registered match with remaining==1: done<=1 in the same cycle as tick.
  - Otherwise, on a match, remaining<=remaining-1.
- Expiry:
  - One-shot: return to IDLE, busy<=0, remaining<=0.
  - Periodic: remaining<=reload and stay in RUN with no gap cycle.
- count_in==0 at start: the block does not enter RUN. done pulses on the next cycle, busy stays 0, and no tick is produced.
- Simultaneous events:
  - start during RUN restarts: reseed, reload, new mode; any pending match in that cycle is discarded (no tick, no done).
  - stop takes priority over start and over a match. It forces IDLE next cycle with no done and no tick.
- tick and done are registered; neither is ever high for two consecutive cycles unless the base period is 1.
- Outputs depend only on registered state; there is no combinational path from inputs to outputs.

Optional Feature:
- Macro: LFSR_TIMER_LOCKUP_EN.
- When defined:
  - Adds output lockup (1 bit, reset 0).
  - If lfsr is ever all-zero in RUN, the next cycle reloads SEED.
  - lockup latches to 1 until reset or the next start.
  - The zero state is not counted as a match.
- When undefined: no lockup port and no detection logic; an all-zero lfsr stays stuck.

Decomposition:
- Package lfsr_timer_pkg holds:
  - the state enum (IDLE, RUN);
  - default TAPS/SEED/TERM constants for 16-bit;
  - a 4-bit test polynomial constant (TAPS=4'hC, SEED=4'hF, TERM=4'h8).
- One natural sub-module, lfsr_prescaler: WIDTH/TAPS/SEED/TERM, inputs advance/reseed, outputs match (registered tick).
- The top level holds the FSM and the down-counter.

Test Plan:
All scenarios use WIDTH=4, TAPS=4'hC, SEED=4'hF, TERM=4'h8 (sequence F,E,C,8), so the base period is 4 clocks. Start is pulsed at cycle 0.
1. One-shot, count_in=3:
   - busy=1 from cycle 1.
   - tick at cycles 5, 9, 13; done at 13 only.
   - busy=0 and remaining=0 from 14.
   - remaining goes 3, 2, 1 at cycles 1, 6, 10.
2. Periodic, count_in=2: done at 9, 17, 25 with ticks every 4 clocks; remaining reloads to 2 at cycle 10 with no lost tick.
3. Pause: one-shot count_in=1, enable=0 during cycles 2-4. lfsr holds E; tick and done both arrive at cycle 8 instead of 5.
4. Stop and restart:
   - stop at cycle 4 (lfsr==8) gives no tick and no done; IDLE at 5.
   - start with count_in=0 gives done one cycle later with busy=0.
   - start at cycle 3 of a RUN reseeds, so the first tick is 5 cycles later.
5. Async reset: rst low at mid-cycle in RUN. Outputs go to 0 and lfsr to F immediately, without a clock edge. Release, then start count_in=1 gives tick and done 5 cycles after start.
6. With LFSR_TIMER_LOCKUP_EN: force lfsr=0 in RUN. The next cycle has lfsr=F and lockup=1; lockup clears on the next start.
